// File: rtl/address_offset_calc_if.sv
// rtl/address_offset_calc_if.sv - operand/control/status bundle for address_offset_calc
interface address_offset_calc_if #(
   parameter int OFFS_WIDTH = 8
);
   logic [OFFS_WIDTH-1:0] mbus;
   logic [1:0]            mode;
   logic                  loadn;
   logic                  outn;
   logic                  busy;
   logic                  wrap;

   modport master (
      output mbus, mode, loadn, outn,
      input  busy, wrap
   );

   modport slave (
      input  mbus, mode, loadn, outn,
      output busy, wrap
   );
endinterface

// File: rtl/address_offset_calc.sv
// rtl/address_offset_calc.sv - slice-serial base+offset address adder with tri-state result bus
module address_offset_calc #(
   parameter int ADDR_WIDTH  = 16,
   parameter int OFFS_WIDTH  = 8,
   parameter int SLICE_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   inout  wire  [ADDR_WIDTH-1:0] abus,
   address_offset_calc_if.slave  bus
);
   localparam int NSLICE = ADDR_WIDTH / SLICE_WIDTH;
   localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

   typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   base_q, base_d;
   logic [ADDR_WIDTH-1:0]   opnd_q, opnd_d;
   logic [ADDR_WIDTH-1:0]   result_q, result_d;
   logic                    neg_q, neg_d;
   logic                    carry_q, carry_d;
   logic                    wrap_q, wrap_d;
   logic                    busy_q, busy_d;

   logic [ADDR_WIDTH-1:0]   opnd_ext;
   logic                    opnd_neg;
   logic [SLICE_WIDTH-1:0]  a_sl;
   logic [SLICE_WIDTH-1:0]  b_sl;
   logic [SLICE_WIDTH:0]    sum;

   // A negative operand turns the final carry into "no borrow", so wrap is its inverse.
   always_comb begin
      opnd_ext = '0;
      opnd_neg = 1'b0;
      case (bus.mode)
         2'b00: begin
            opnd_ext = ADDR_WIDTH'($signed(bus.mbus));
            opnd_neg = bus.mbus[OFFS_WIDTH-1];
         end
         2'b01:   opnd_ext = ADDR_WIDTH'(bus.mbus);
         2'b10:   opnd_ext = ADDR_WIDTH'(1);
         default: begin
            opnd_ext = '1;
            opnd_neg = 1'b1;
         end
      endcase
   end

   always_comb begin
      a_sl = '0;
      b_sl = '0;
      for (int k = 0; k < NSLICE; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            a_sl = base_q[k*SLICE_WIDTH +: SLICE_WIDTH];
            b_sl = opnd_q[k*SLICE_WIDTH +: SLICE_WIDTH];
         end
      end
      sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_WIDTH{1'b0}}, carry_q};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      base_d   = base_q;
      opnd_d   = opnd_q;
      result_d = result_q;
      neg_d    = neg_q;
      carry_d  = carry_q;
      wrap_d   = wrap_q;
      busy_d   = busy_q;
      case (state_q)
         IDLE: begin
            if (!bus.loadn) begin
               base_d  = abus;
               opnd_d  = opnd_ext;
               neg_d   = opnd_neg;
               carry_d = 1'b0;
               cnt_d   = '0;
               state_d = CALC;
               busy_d  = 1'b1;
            end
         end
         default: begin
            carry_d = sum[SLICE_WIDTH];
            for (int k = 0; k < NSLICE; k++) begin
               if (cnt_q == CNT_W'(k)) begin
                  result_d[k*SLICE_WIDTH +: SLICE_WIDTH] = sum[SLICE_WIDTH-1:0];
               end
            end
            if (cnt_q == LAST_SLICE) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               cnt_d   = '0;
               wrap_d  = sum[SLICE_WIDTH] ^ neg_q;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         base_q   <= '0;
         opnd_q   <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
         carry_q  <= 1'b0;
         wrap_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         base_q   <= base_d;
         opnd_q   <= opnd_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         carry_q  <= carry_d;
         wrap_q   <= wrap_d;
         busy_q   <= busy_d;
      end
   end

   // Released while a load is requested so the external driver owns the base cycle.
   assign abus     = (!reset && !busy_q && !bus.outn && bus.loadn) ? result_q : {ADDR_WIDTH{1'bz}};
   assign bus.busy = busy_q;
   assign bus.wrap = wrap_q;
endmodule

// File: tb/tb_address_offset_calc.sv
// tb/tb_address_offset_calc.sv - scoreboard bench for default and 24-bit address_offset_calc
module tb_address_offset_calc;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   address_offset_calc_if #(.OFFS_WIDTH(8)) d_if ();
   address_offset_calc_if #(.OFFS_WIDTH(8)) w_if ();

   wire  [15:0] d_abus;
   wire  [23:0] w_abus;
   logic [15:0] d_drv;
   logic [23:0] w_drv;
   logic        d_drv_en;
   logic        w_drv_en;
   assign d_abus = d_drv_en ? d_drv : 16'bz;
   assign w_abus = w_drv_en ? w_drv : 24'bz;

   address_offset_calc #(.ADDR_WIDTH(16), .OFFS_WIDTH(8), .SLICE_WIDTH(8)) u_dut (
      .clk   (clk),
      .reset (reset),
      .abus  (d_abus),
      .bus   (d_if)
   );

   address_offset_calc #(.ADDR_WIDTH(24), .OFFS_WIDTH(8), .SLICE_WIDTH(8)) u_dut_w (
      .clk   (clk),
      .reset (reset),
      .abus  (w_abus),
      .bus   (w_if)
   );

   typedef struct {
      logic [23:0] res;
      logic        wrap;
      int          nbusy;
   } exp_t;

   typedef struct {
      logic [15:0] base;
      logic [7:0]  off;
      logic [1:0]  md;
      logic [15:0] res;
      logic        wrap;
   } vec_t;

   exp_t d_q[$];
   exp_t w_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   d_prev   = 1'b0;
   bit   w_prev   = 1'b0;
   int   d_cnt    = 0;
   int   w_cnt    = 0;
   logic last_wrap;

   vec_t vecs[9] = '{
      '{16'hFCE1, 8'hA8, 2'b00, 16'hFC89, 1'b0},
      '{16'hFCE1, 8'hA8, 2'b01, 16'hFD89, 1'b0},
      '{16'hFFF0, 8'h20, 2'b01, 16'h0010, 1'b1},
      '{16'h00FF, 8'h55, 2'b10, 16'h0100, 1'b0},
      '{16'h0000, 8'h55, 2'b11, 16'hFFFF, 1'b1},
      '{16'hFFFF, 8'h55, 2'b10, 16'h0000, 1'b1},
      '{16'h1000, 8'h7F, 2'b00, 16'h107F, 1'b0},
      '{16'h8000, 8'h00, 2'b11, 16'h7FFF, 1'b0},
      '{16'h0005, 8'hF0, 2'b00, 16'hFFF5, 1'b1}
   };

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         d_prev = 1'b0;
         d_cnt  = 0;
      end else begin
         if (d_if.busy) d_cnt++;
         if (d_prev && !d_if.busy) begin
            if (d_q.size() == 0) begin
               chk("d_unexpected_done", 32'd1, 32'd0);
            end else begin
               e = d_q.pop_front();
               chk("d_result", {16'd0, d_abus}, {8'd0, e.res});
               chk("d_wrap", {31'd0, d_if.wrap}, {31'd0, e.wrap});
               chk("d_busy_cycles", d_cnt, e.nbusy);
            end
            d_cnt = 0;
         end
         d_prev = d_if.busy;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         w_prev = 1'b0;
         w_cnt  = 0;
      end else begin
         if (w_if.busy) w_cnt++;
         if (w_prev && !w_if.busy) begin
            if (w_q.size() == 0) begin
               chk("w_unexpected_done", 32'd1, 32'd0);
            end else begin
               e = w_q.pop_front();
               chk("w_result", {8'd0, w_abus}, {8'd0, e.res});
               chk("w_wrap", {31'd0, w_if.wrap}, {31'd0, e.wrap});
               chk("w_busy_cycles", w_cnt, e.nbusy);
            end
            w_cnt = 0;
         end
         w_prev = w_if.busy;
      end
   end

   task automatic wait_idle(input bit wide);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((wide ? w_if.busy : d_if.busy) && n < 12);
      chk("idle_timeout", {31'd0, (wide ? w_if.busy : d_if.busy)}, 32'd0);
   endtask

   task automatic start_d(input logic [15:0] base, input logic [7:0] off, input logic [1:0] md,
                          input logic [15:0] res, input logic wr);
      exp_t e;
      e.res = {8'd0, res}; e.wrap = wr; e.nbusy = 2;
      d_q.push_back(e);
      d_drv = base; d_drv_en = 1'b1; d_if.mbus = off; d_if.mode = md; d_if.loadn = 1'b0;
      @(negedge clk);
      chk("d_load_no_contention", {16'd0, d_abus}, {16'd0, base});
      @(posedge clk); #1;
      d_if.loadn = 1'b1; d_drv_en = 1'b0; d_if.mbus = ~off; d_if.mode = ~md;
      wait_idle(1'b0);
      @(posedge clk); #1;
   endtask

   task automatic start_w(input logic [23:0] base, input logic [7:0] off, input logic [1:0] md,
                          input logic [23:0] res, input logic wr);
      exp_t e;
      e.res = res; e.wrap = wr; e.nbusy = 3;
      w_q.push_back(e);
      w_drv = base; w_drv_en = 1'b1; w_if.mbus = off; w_if.mode = md; w_if.loadn = 1'b0;
      @(negedge clk);
      chk("w_load_no_contention", {8'd0, w_abus}, {8'd0, base});
      @(posedge clk); #1;
      w_if.loadn = 1'b1; w_drv_en = 1'b0; w_if.mbus = ~off; w_if.mode = ~md;
      wait_idle(1'b1);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e;
      reset = 1'b1;
      d_drv = '0; d_drv_en = 1'b0; w_drv = '0; w_drv_en = 1'b0;
      d_if.mbus = '0; d_if.mode = '0; d_if.loadn = 1'b1; d_if.outn = 1'b0;
      w_if.mbus = '0; w_if.mode = '0; w_if.loadn = 1'b1; w_if.outn = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'd0, d_if.busy}, 32'd0);
      chk("rst_wrap", {31'd0, d_if.wrap}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // first edge after reset release carries the load
      foreach (vecs[i]) begin
         start_d(vecs[i].base, vecs[i].off, vecs[i].md, vecs[i].res, vecs[i].wrap);
         last_wrap = vecs[i].wrap;
      end

      repeat (3) @(negedge clk);
      chk("hold_result", {16'd0, d_abus}, 32'h0000FFF5);
      chk("hold_wrap", {31'd0, d_if.wrap}, {31'd0, last_wrap});
      @(posedge clk); #1;

      // reload attempt, operand changes and a zero-driving probe while busy
      e.res = 24'h001239; e.wrap = 1'b0; e.nbusy = 2;
      d_q.push_back(e);
      d_drv = 16'h1234; d_drv_en = 1'b1; d_if.mbus = 8'h05; d_if.mode = 2'b01; d_if.loadn = 1'b0;
      @(posedge clk); #1;
      d_if.mbus = 8'hFF; d_if.mode = 2'b00; d_drv = 16'h0000;
      @(negedge clk);
      chk("hiz_while_busy", {16'd0, d_abus}, 32'd0);
      chk("busy_in_calc", {31'd0, d_if.busy}, 32'd1);
      chk("wrap_stable_in_calc", {31'd0, d_if.wrap}, {31'd0, last_wrap});
      @(posedge clk); #1;
      d_if.loadn = 1'b1; d_drv_en = 1'b0;
      wait_idle(1'b0);
      @(posedge clk); #1;

      start_d(16'h0000, 8'h00, 2'b11, 16'hFFFF, 1'b1);

      // abort on the first CALC cycle
      d_drv = 16'h4321; d_drv_en = 1'b1; d_if.mbus = 8'h10; d_if.mode = 2'b01; d_if.loadn = 1'b0;
      @(posedge clk); #1;
      d_if.loadn = 1'b1; d_drv_en = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("abort_busy", {31'd0, d_if.busy}, 32'd0);
      chk("abort_result", {16'd0, d_abus}, 32'd0);
      chk("abort_wrap", {31'd0, d_if.wrap}, 32'd0);
      @(posedge clk); #1;

      start_d(16'h00FF, 8'h00, 2'b10, 16'h0100, 1'b0);

      start_w(24'h00FFFF, 8'h01, 2'b00, 24'h010000, 1'b0);
      start_w(24'h000000, 8'h00, 2'b11, 24'hFFFFFF, 1'b1);
      start_w(24'h7FFFFF, 8'h80, 2'b00, 24'h7FFF7F, 1'b0);

      repeat (3) @(negedge clk);
      chk("d_queue_drained", d_q.size(), 32'd0);
      chk("w_queue_drained", w_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/address_offset_calc.md
ADDRESS_OFFSET_CALC -- requirements
Module: address_offset_calc

Interface
REQ-001 Parameter ADDR_WIDTH, default 16: address register and abus width in bits.
REQ-002 Parameter OFFS_WIDTH, default 8: offset width on mbus, at most ADDR_WIDTH.
REQ-003 Parameter SLICE_WIDTH, default 8: adder bits processed per cycle; ADDR_WIDTH SHALL be an integer multiple of it; NSLICE = ADDR_WIDTH/SLICE_WIDTH.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 abus  inout  ADDR_WIDTH  address bus; base address sampled in; result driven out; high-Z otherwise.
REQ-007 mbus  input  OFFS_WIDTH  offset operand.
REQ-008 mode  input  2  00 signed offset, 01 unsigned offset, 10 increment by 1, 11 decrement by 1.
REQ-009 loadn  input  1  active-low start strobe.
REQ-010 outn  input  1  active-low result output enable.
REQ-011 busy  output  1  high while a calculation is in progress.
REQ-012 wrap  output  1  high when the last result wrapped modulo 2^ADDR_WIDTH.

Function
REQ-013 States SHALL be IDLE and CALC; the slice counter runs 0..NSLICE-1 in CALC.
REQ-014 IDLE with loadn=0 at an edge: latch abus as base, latch operand, latch mode, clear carry, enter CALC at slice 0, busy=1.
REQ-015 Operand: mode 00 sign-extends mbus to ADDR_WIDTH; mode 01 zero-extends it; mode 10 is +1; mode 11 is all-ones (-1); mbus is ignored in modes 10/11.
REQ-016 Each CALC edge SHALL add slice k of base and operand plus the stored carry, write slice k of the result register, and store the carry-out, least-significant slice first.
REQ-017 After the edge processing slice NSLICE-1, the state SHALL return to IDLE with busy=0; latency from the loadn edge to busy=0 is NSLICE+1 edges (default: 3 edges, 2 busy cycles).
REQ-018 On completion, wrap = final carry-out in mode 01 and mode 10; wrap = NOT final carry-out in mode 00 with a negative offset and mode 11; wrap = final carry-out in mode 00 with a non-negative offset.
REQ-019 Arithmetic SHALL be modulo 2^ADDR_WIDTH; intermediate carries SHALL propagate across slice boundaries.
REQ-020 abus SHALL be driven with the result register only when outn=0 and busy=0, and SHALL be high-Z otherwise, including throughout CALC.
REQ-021 loadn=0 during CALC SHALL be ignored; no restart, no change to latched operands.
REQ-022 loadn=0 and outn=0 together in IDLE: the base is taken from the external abus driver; the block SHALL NOT drive abus on that cycle.
REQ-023 The result and wrap SHALL hold their values in IDLE until the next completed calculation; wrap is unchanged during CALC.
REQ-024 Mode and mbus changes during CALC SHALL NOT affect the result.

Reset
REQ-025 reset=1 at an edge: state=IDLE, busy=0, wrap=0, result=0, carry=0, slice counter=0; abus high-Z on that cycle.
REQ-026 Reset SHALL take priority over loadn and SHALL abort a calculation in progress; no partial result remains.
REQ-027 The first edge after reset deasserts SHALL accept loadn normally.

Verification
REQ-028 Default params, mode 00, abus=64737, mbus=168 (-88), loadn=0 for one edge: busy=1 for 2 cycles, then with outn=0 abus=64649 and wrap=0.
REQ-029 Mode 01, abus=64737, mbus=168: result 64905, wrap=0. Mode 01, abus=0xFFF0, mbus=0x20: result 0x0010, wrap=1.
REQ-030 Mode 10, abus=0x00FF: result 0x0100 (carry crosses the slice), wrap=0. Mode 11, abus=0x0000: result 0xFFFF, wrap=1. Mode 10, abus=0xFFFF: result 0x0000, wrap=1.
REQ-031 Start 0x1234 + 5 in mode 01, pulse loadn again and change mbus mid-CALC: result 0x1239; abus high-Z while busy even with outn=0.
REQ-032 Reset asserted on the first CALC cycle: busy=0 on the next cycle; outn=0 then shows abus=0x0000, wrap=0.
REQ-033 ADDR_WIDTH=24, SLICE_WIDTH=8, mode 00, abus=0x00FFFF, mbus=0x01: busy for 3 cycles, result 0x010000, wrap=0.
